// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared definitions for the pedestrian crossing controller:
//   - ped_state_t   : crossing FSM states
//   - LAMP_*        : vehicle lamp codes, packed as {red, amber, green}
//   - lamp_is_valid : true for the four codes the sequencer can produce
//   - lamp_next     : the legal successor of a lamp code
package traffic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_WALK,
      ST_CLEAR,
      ST_FAULT
   } ped_state_t;

   localparam logic [2:0] LAMP_RED       = 3'b100;
   localparam logic [2:0] LAMP_RED_AMBER = 3'b110;
   localparam logic [2:0] LAMP_GREEN     = 3'b001;
   localparam logic [2:0] LAMP_AMBER     = 3'b010;

   function automatic logic lamp_is_valid(input logic [2:0] lamp);
      case (lamp)
         LAMP_RED, LAMP_RED_AMBER, LAMP_GREEN, LAMP_AMBER: lamp_is_valid = 1'b1;
         default:                                          lamp_is_valid = 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] lamp_next(input logic [2:0] lamp);
      case (lamp)
         LAMP_RED:       lamp_next = LAMP_RED_AMBER;
         LAMP_RED_AMBER: lamp_next = LAMP_GREEN;
         LAMP_GREEN:     lamp_next = LAMP_AMBER;
         default:        lamp_next = LAMP_RED;
      endcase
   endfunction

endpackage

// File: rtl/ped_crossing_if.sv
// ped_crossing_if
// Signal bundle between the traffic-light side and the crossing controller.
//   red, amber, green : vehicle lamps from the sequencer
//   button            : pedestrian request
//   hold              : freezes the sequencer while high
//   walk, dont_walk   : pedestrian lamps
//   wait_lamp         : request-registered indicator
//   countdown         : remaining walk cycles (0 outside the walk phase)
//   fault             : sticky sequence/safety fault
// The master modport is the environment; the slave modport is the controller.
interface ped_crossing_if;
   logic       red;
   logic       amber;
   logic       green;
   logic       button;
   logic       hold;
   logic       walk;
   logic       dont_walk;
   logic       wait_lamp;
   logic [3:0] countdown;
   logic       fault;

   modport master (
      output red, amber, green, button,
      input  hold, walk, dont_walk, wait_lamp, countdown, fault
   );

   modport slave (
      input  red, amber, green, button,
      output hold, walk, dont_walk, wait_lamp, countdown, fault
   );
endinterface

// File: rtl/lamp_seq_check.sv
// lamp_seq_check
// Watches the vehicle lamp code and flags illegal transitions.
//   clk, rst : clock and asynchronous active-high reset
//   lamp     : current {red, amber, green}
//   illegal  : high for a cycle in which lamp is an unknown code or is
//              neither a repeat nor the legal successor of the previous code
// The previous-lamp register is loaded on the first cycle after reset and
// no check is made on that cycle.
module lamp_seq_check
   import traffic_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] lamp,
   output logic       illegal
);

   logic [2:0] prev_reg;
   logic       primed_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_reg   <= LAMP_RED;
         primed_reg <= 1'b0;
      end else begin
         prev_reg   <= lamp;
         primed_reg <= 1'b1;
      end
   end

   always_comb begin
      illegal = 1'b0;
      if (primed_reg) begin
         if (!lamp_is_valid(lamp))
            illegal = 1'b1;
         else if (lamp != prev_reg && lamp != lamp_next(prev_reg))
            illegal = 1'b1;
      end
   end

endmodule

// File: rtl/ped_crossing.sv
// ped_crossing
// Pedestrian crossing controller downstream of the traffic-light sequencer.
// Latches a request, starts the walk phase when the vehicle lamps leave
// amber, holds the vehicle lights on red through walk and clearance, and
// latches a sticky fault on an illegal lamp sequence or on a non-red lamp
// while holding.
//   clk, rst : clock and asynchronous active-high reset
//   ped      : ped_crossing_if.slave (lamps/button in, pedestrian outputs out)
// Parameters: WALK_CYCLES (1..15), CLEAR_CYCLES (1..15), FLASH_DIV.
// Build option: define PED_FLASH_EN to flash dont_walk during clearance,
// toggling every FLASH_DIV cycles; otherwise dont_walk is steady.
module ped_crossing
   import traffic_pkg::*;
#(
   parameter int WALK_CYCLES  = 8,
   parameter int CLEAR_CYCLES = 4,
   parameter int FLASH_DIV    = 2
) (
   input logic           clk,
   input logic           rst,
   ped_crossing_if.slave ped
);

`ifdef PED_FLASH_EN
   localparam bit FLASH_ON = 1'b1;
`else
   localparam bit FLASH_ON = 1'b0;
`endif

   logic [2:0] lamp;
   logic       illegal;

   assign lamp = {ped.red, ped.amber, ped.green};

   lamp_seq_check u_check (
      .clk     (clk),
      .rst     (rst),
      .lamp    (lamp),
      .illegal (illegal)
   );

   ped_state_t state_reg;
   logic       hold_reg;
   logic       walk_reg;
   logic       dont_walk_reg;
   logic       wait_reg;
   logic [3:0] countdown_reg;
   logic       fault_reg;
   logic [3:0] phase_reg;     // cycles left in the current WALK/CLEAR phase
   logic [3:0] flash_reg;     // cycles since the last dont_walk toggle
   logic       pending_reg;   // request made during WALK/CLEAR

   logic safety_trip;
   assign safety_trip = (state_reg == ST_WALK || state_reg == ST_CLEAR) &&
                        (lamp != LAMP_RED);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         hold_reg      <= 1'b0;
         walk_reg      <= 1'b0;
         dont_walk_reg <= 1'b1;
         wait_reg      <= 1'b0;
         countdown_reg <= 4'd0;
         fault_reg     <= 1'b0;
         phase_reg     <= 4'd0;
         flash_reg     <= 4'd0;
         pending_reg   <= 1'b0;
      end else if (illegal || safety_trip) begin
         // Fault overrides every other transition.
         state_reg     <= ST_FAULT;
         hold_reg      <= 1'b0;
         walk_reg      <= 1'b0;
         dont_walk_reg <= 1'b1;
         wait_reg      <= 1'b0;
         countdown_reg <= 4'd0;
         fault_reg     <= 1'b1;
         pending_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (ped.button) begin
                  state_reg <= ST_ARMED;
                  wait_reg  <= 1'b1;
               end
            end
            ST_ARMED: begin
               // The sequencer moves amber->red on this same edge, so hold
               // rises just in time to pin it on red.
               if (lamp == LAMP_AMBER) begin
                  state_reg     <= ST_WALK;
                  hold_reg      <= 1'b1;
                  walk_reg      <= 1'b1;
                  dont_walk_reg <= 1'b0;
                  wait_reg      <= 1'b0;
                  pending_reg   <= 1'b0;
                  countdown_reg <= 4'(WALK_CYCLES);
                  phase_reg     <= 4'(WALK_CYCLES);
               end
            end
            ST_WALK: begin
               if (ped.button) begin
                  pending_reg <= 1'b1;
                  wait_reg    <= 1'b1;
               end
               if (phase_reg == 4'd1) begin
                  state_reg     <= ST_CLEAR;
                  walk_reg      <= 1'b0;
                  dont_walk_reg <= 1'b1;
                  countdown_reg <= 4'd0;
                  phase_reg     <= 4'(CLEAR_CYCLES);
                  flash_reg     <= 4'd0;
               end else begin
                  phase_reg     <= phase_reg - 4'd1;
                  countdown_reg <= countdown_reg - 4'd1;
               end
            end
            ST_CLEAR: begin
               if (phase_reg == 4'd1) begin
                  hold_reg      <= 1'b0;
                  dont_walk_reg <= 1'b1;
                  pending_reg   <= 1'b0;
                  if (pending_reg || ped.button) begin
                     state_reg <= ST_ARMED;
                     wait_reg  <= 1'b1;
                  end else begin
                     state_reg <= ST_IDLE;
                     wait_reg  <= 1'b0;
                  end
               end else begin
                  phase_reg <= phase_reg - 4'd1;
                  if (ped.button) begin
                     pending_reg <= 1'b1;
                     wait_reg    <= 1'b1;
                  end
                  if (FLASH_ON && flash_reg == 4'(FLASH_DIV - 1)) begin
                     dont_walk_reg <= !dont_walk_reg;
                     flash_reg     <= 4'd0;
                  end else begin
                     flash_reg <= flash_reg + 4'd1;
                  end
               end
            end
            ST_FAULT: begin
               // Sticky: only reset leaves.
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign ped.hold      = hold_reg;
   assign ped.walk      = walk_reg;
   assign ped.dont_walk = dont_walk_reg;
   assign ped.wait_lamp = wait_reg;
   assign ped.countdown = countdown_reg;
   assign ped.fault     = fault_reg;

endmodule

// File: tb/tb_ped_crossing.sv
// tb_ped_crossing
// Directed testbench for ped_crossing with default parameters
// (WALK_CYCLES=8, CLEAR_CYCLES=4, FLASH_DIV=2). Inputs change 1 time unit
// after the rising edge; outputs are sampled at the same point.
// Output vector bits: {hold, walk, dont_walk, wait_lamp, fault}.
module tb_ped_crossing;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   ped_crossing_if pif();

   ped_crossing dut (
      .clk (clk),
      .rst (rst),
      .ped (pif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [4:0] O_IDLE   = 5'b00100;
   localparam logic [4:0] O_ARMED  = 5'b00110;
   localparam logic [4:0] O_WALK   = 5'b11000;
   localparam logic [4:0] O_WALK_P = 5'b11010;
   localparam logic [4:0] O_FAULT  = 5'b00101;

   function automatic logic [4:0] outs();
      return {pif.hold, pif.walk, pif.dont_walk, pif.wait_lamp, pif.fault};
   endfunction

   task automatic cyc(input logic [2:0] l, input logic b);
      {pif.red, pif.amber, pif.green} = l;
      pif.button = b;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [2:0] l);
      {pif.red, pif.amber, pif.green} = l;
      pif.button = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(3'b100);
      rst = 1'b1;
      #1;
      checks++;
      if (outs() !== O_IDLE) begin
         errors++;
         $display("FAIL reset_outs: got %b expected %b", outs(), O_IDLE);
      end
      checks++;
      if (pif.countdown !== 4'd0) begin
         errors++;
         $display("FAIL reset_countdown: got %0d expected 0", pif.countdown);
      end
      rst = 1'b0;
      $display("reset: outs=%b countdown=%0d", outs(), pif.countdown);
   endtask

   task automatic test_idle_cycle();
      logic [2:0] seq [5];
      seq = '{3'b100, 3'b110, 3'b001, 3'b010, 3'b100};
      for (int i = 0; i < 5; i++) begin
         cyc(seq[i], 1'b0);
         checks++;
         if (outs() !== O_IDLE) begin
            errors++;
            $display("FAIL idle_cycle[%0d]: got %b expected %b", i, outs(), O_IDLE);
         end
         $display("idle: lamp=%b outs=%b", seq[i], outs());
      end
   endtask

   task automatic test_walk();
      logic [4:0] exp;
      cyc(3'b110, 1'b0);
      cyc(3'b001, 1'b1);
      checks++;
      if (outs() !== O_ARMED) begin
         errors++;
         $display("FAIL walk_request: got %b expected %b", outs(), O_ARMED);
      end
      cyc(3'b001, 1'b0);
      cyc(3'b010, 1'b0);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) cyc(3'b100, 1'b0);
         checks++;
         if (outs() !== O_WALK || pif.countdown !== 4'(8 - k)) begin
            errors++;
            $display("FAIL walk_phase[%0d]: got %b/%0d expected %b/%0d",
                     k, outs(), pif.countdown, O_WALK, 8 - k);
         end
         $display("walk: k=%0d outs=%b countdown=%0d", k, outs(), pif.countdown);
      end
      for (int c = 0; c < 4; c++) begin
         cyc(3'b100, 1'b0);
`ifdef PED_FLASH_EN
         exp = {1'b1, 1'b0, (c < 2), 2'b00};
`else
         exp = 5'b10100;
`endif
         checks++;
         if (outs() !== exp || pif.countdown !== 4'd0) begin
            errors++;
            $display("FAIL clear_phase[%0d]: got %b/%0d expected %b/0",
                     c, outs(), pif.countdown, exp);
         end
         $display("clear: c=%0d outs=%b", c, outs());
      end
      cyc(3'b100, 1'b0);
      checks++;
      if (outs() !== O_IDLE) begin
         errors++;
         $display("FAIL walk_exit: got %b expected %b", outs(), O_IDLE);
      end
      $display("walk exit: outs=%b", outs());
   endtask

   task automatic test_back_to_back();
      logic [4:0] exp;
      cyc(3'b110, 1'b0);
      cyc(3'b001, 1'b1);
      cyc(3'b010, 1'b0);
      cyc(3'b100, 1'b1);
      checks++;
      if (outs() !== O_WALK_P || pif.countdown !== 4'd7) begin
         errors++;
         $display("FAIL b2b_press: got %b/%0d expected %b/7", outs(), pif.countdown, O_WALK_P);
      end
      for (int k = 0; k < 10; k++) begin
         cyc(3'b100, 1'b0);
         if (k < 6) exp = O_WALK_P;
`ifdef PED_FLASH_EN
         else exp = {1'b1, 1'b0, (k < 8), 1'b1, 1'b0};
`else
         else exp = 5'b10110;
`endif
         checks++;
         if (outs() !== exp) begin
            errors++;
            $display("FAIL b2b_pending[%0d]: got %b expected %b", k, outs(), exp);
         end
         $display("b2b: k=%0d outs=%b", k, outs());
      end
      cyc(3'b100, 1'b0);
      checks++;
      if (outs() !== O_ARMED) begin
         errors++;
         $display("FAIL b2b_rearm: got %b expected %b", outs(), O_ARMED);
      end
      cyc(3'b110, 1'b0);
      cyc(3'b001, 1'b0);
      checks++;
      if (outs() !== O_ARMED) begin
         errors++;
         $display("FAIL b2b_waiting: got %b expected %b", outs(), O_ARMED);
      end
      cyc(3'b010, 1'b0);
      checks++;
      if (outs() !== O_WALK || pif.countdown !== 4'd8) begin
         errors++;
         $display("FAIL b2b_second_walk: got %b/%0d expected %b/8", outs(), pif.countdown, O_WALK);
      end
      $display("b2b second walk: outs=%b countdown=%0d", outs(), pif.countdown);
   endtask

   // Continues from the second walk entered by test_back_to_back.
   task automatic test_safety_fault();
      logic [2:0] seq [3];
      cyc(3'b100, 1'b0);
      checks++;
      if (outs() !== O_WALK || pif.countdown !== 4'd7) begin
         errors++;
         $display("FAIL safety_pre: got %b/%0d expected %b/7", outs(), pif.countdown, O_WALK);
      end
      cyc(3'b110, 1'b0);
      checks++;
      if (outs() !== O_FAULT || pif.countdown !== 4'd0) begin
         errors++;
         $display("FAIL safety_trip: got %b/%0d expected %b/0", outs(), pif.countdown, O_FAULT);
      end
      seq = '{3'b001, 3'b010, 3'b100};
      for (int i = 0; i < 3; i++) begin
         cyc(seq[i], 1'b1);
         checks++;
         if (outs() !== O_FAULT) begin
            errors++;
            $display("FAIL safety_sticky[%0d]: got %b expected %b", i, outs(), O_FAULT);
         end
      end
      $display("safety fault: outs=%b", outs());
   endtask

   task automatic test_illegal_seq();
      do_reset(3'b010);
      // First cycle after reset only loads the previous-lamp register.
      cyc(3'b010, 1'b0);
      checks++;
      if (outs() !== O_IDLE) begin
         errors++;
         $display("FAIL illegal_first_cycle: got %b expected %b", outs(), O_IDLE);
      end
      cyc(3'b100, 1'b0);
      cyc(3'b100, 1'b0);
      checks++;
      if (outs() !== O_IDLE) begin
         errors++;
         $display("FAIL illegal_legal_repeat: got %b expected %b", outs(), O_IDLE);
      end
      cyc(3'b001, 1'b0);
      checks++;
      if (outs() !== O_FAULT) begin
         errors++;
         $display("FAIL illegal_red_to_green: got %b expected %b", outs(), O_FAULT);
      end
      cyc(3'b100, 1'b1);
      checks++;
      if (outs() !== O_FAULT) begin
         errors++;
         $display("FAIL illegal_sticky: got %b expected %b", outs(), O_FAULT);
      end
      $display("illegal sequence: outs=%b", outs());
   endtask

   task automatic test_async_reset();
      do_reset(3'b100);
      cyc(3'b100, 1'b0);
      cyc(3'b110, 1'b0);
      cyc(3'b001, 1'b1);
      cyc(3'b010, 1'b0);
      cyc(3'b100, 1'b0);
      checks++;
      if (outs() !== O_WALK || pif.countdown !== 4'd7) begin
         errors++;
         $display("FAIL async_pre: got %b/%0d expected %b/7", outs(), pif.countdown, O_WALK);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (outs() !== O_IDLE || pif.countdown !== 4'd0) begin
         errors++;
         $display("FAIL async_reset: got %b/%0d expected %b/0", outs(), pif.countdown, O_IDLE);
      end
      #1;
      rst = 1'b0;
      cyc(3'b100, 1'b0);
      checks++;
      if (outs() !== O_IDLE) begin
         errors++;
         $display("FAIL async_after: got %b expected %b", outs(), O_IDLE);
      end
      $display("async reset: outs=%b", outs());
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst        = 1'b1;
      pif.red    = 1'b1;
      pif.amber  = 1'b0;
      pif.green  = 1'b0;
      pif.button = 1'b0;
      test_reset();
      test_idle_cycle();
      test_walk();
      test_back_to_back();
      test_safety_fault();
      test_illegal_seq();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
